// File: rtl/scan_sequencer_16_pkg.sv
// Shared definitions for the 16-channel demux scan sequencer.
// State encoding, channel count and default guard length.
package scan_sequencer_16_pkg;

   localparam int NCH           = 16;
   localparam int GUARD_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GUARD = 2'd1,
      DWELL = 2'd2
   } state_e;

endpackage

// File: rtl/scan_sequencer_16_next_channel_finder.sv
// Combinational search of a channel mask: next enabled channel above cur and lowest enabled channel.
// Zero latency; no flow control.
module next_channel_finder
   import scan_sequencer_16_pkg::*;
(
   input  logic [NCH-1:0] mask,
   input  logic [3:0]     cur,
   output logic [3:0]     next,
   output logic           wrap,
   output logic [3:0]     first
);

   // Descending loops so the lowest qualifying channel is the last one written.
   always_comb begin
      next  = 4'd0;
      wrap  = 1'b1;
      first = 4'd0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            first = 4'(i);
            if (i > int'(cur)) begin
               next = 4'(i);
               wrap = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/scan_sequencer_16.sv
// Scans enabled demux channels in ascending order: GUARD cycles with E low, then max(dwell,1) cycles E high.
// First E high GUARD+1 cycles after start; stop aborts to IDLE next cycle; start while busy is ignored.
module scan_sequencer_16
   import scan_sequencer_16_pkg::NCH;
   import scan_sequencer_16_pkg::GUARD_DEFAULT;
   import scan_sequencer_16_pkg::state_e;
#(
   parameter int DWELL_W = 16,
   parameter int GUARD   = GUARD_DEFAULT
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               cont,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [NCH-1:0]     ch_mask,
   output logic [3:0]         S,
   output logic               E,
   output logic               busy,
   output logic               frame_done
);

   localparam logic [3:0] GLOAD = 4'(GUARD - 1);

   state_e             state;
   logic [NCH-1:0]     mask_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] dcnt;
   logic               cont_q;
   logic [3:0]         gcnt;

   logic [NCH-1:0]     find_mask;
   logic [3:0]         nxt_ch;
   logic [3:0]         first_ch;
   logic               wrap;

   // In IDLE the finder looks at the live mask so the first channel is known at start.
   assign find_mask = (state == scan_sequencer_16_pkg::IDLE) ? ch_mask : mask_q;

   next_channel_finder u_find (
      .mask  (find_mask),
      .cur   (S),
      .next  (nxt_ch),
      .wrap  (wrap),
      .first (first_ch)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= scan_sequencer_16_pkg::IDLE;
         S          <= 4'd0;
         E          <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         mask_q     <= '0;
         dwell_q    <= '0;
         cont_q     <= 1'b0;
         dcnt       <= '0;
         gcnt       <= 4'd0;
      end else begin
         frame_done <= 1'b0;
         if (stop && state != scan_sequencer_16_pkg::IDLE) begin
            state <= scan_sequencer_16_pkg::IDLE;
            E     <= 1'b0;
            busy  <= 1'b0;
         end else begin
            case (state)
               scan_sequencer_16_pkg::IDLE: begin
                  if (start && !stop && ch_mask != '0) begin
                     mask_q  <= ch_mask;
                     dwell_q <= (dwell == '0) ? DWELL_W'(1) : dwell;
                     cont_q  <= cont;
                     S       <= first_ch;
                     gcnt    <= GLOAD;
                     E       <= 1'b0;
                     busy    <= 1'b1;
                     state   <= scan_sequencer_16_pkg::GUARD;
                  end
               end
               scan_sequencer_16_pkg::GUARD: begin
                  if (gcnt == 4'd0) begin
                     E     <= 1'b1;
                     dcnt  <= dwell_q - DWELL_W'(1);
                     state <= scan_sequencer_16_pkg::DWELL;
                  end else begin
                     gcnt <= gcnt - 4'd1;
                  end
               end
               scan_sequencer_16_pkg::DWELL: begin
                  if (dcnt == '0) begin
                     E <= 1'b0;
                     if (!wrap) begin
                        S     <= nxt_ch;
                        gcnt  <= GLOAD;
                        state <= scan_sequencer_16_pkg::GUARD;
                     end else begin
                        frame_done <= 1'b1;
                        if (cont_q) begin
                           S     <= first_ch;
                           gcnt  <= GLOAD;
                           state <= scan_sequencer_16_pkg::GUARD;
                        end else begin
                           busy  <= 1'b0;
                           state <= scan_sequencer_16_pkg::IDLE;
                        end
                     end
                  end else begin
                     dcnt <= dcnt - DWELL_W'(1);
                  end
               end
               default: begin
                  E     <= 1'b0;
                  busy  <= 1'b0;
                  state <= scan_sequencer_16_pkg::IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_scan_sequencer_16.sv
// Scoreboard bench: stimulus pushes cycle-tagged expected {S,E,busy,frame_done}; a negedge monitor pops and compares.
module tb_scan_sequencer_16;

   localparam int G   = 2;
   localparam int BIG = 1000000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stop, cont;
   logic [15:0] dwell;
   logic [15:0] ch_mask;
   logic [3:0]  S;
   logic        E, busy, frame_done;

   typedef struct {
      int         cyc;
      logic [6:0] v;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   scan_sequencer_16 #(.DWELL_W(16), .GUARD(G)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .cont       (cont),
      .dwell      (dwell),
      .ch_mask    (ch_mask),
      .S          (S),
      .E          (E),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares whenever the head entry is due this cycle.
   initial begin
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missed_cycle: expectation for cycle %0d never sampled (now %0d)", q[0].cyc, cyc);
            void'(q.pop_front());
         end
         if (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if ({S, E, busy, frame_done} !== e.v) begin
               n_fail++;
               $display("FAIL outputs@cyc%0d: got S=%0d E=%b busy=%b fd=%b, want S=%0d E=%b busy=%b fd=%b",
                        cyc, S, E, busy, frame_done, e.v[6:3], e.v[2], e.v[1], e.v[0]);
            end
         end
      end
   end

   task automatic expect_at(input int c, input logic [3:0] s, input logic e, input logic b, input logic fd);
      exp_t x;
      x.cyc = c;
      x.v   = {s, e, b, fd};
      q.push_back(x);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected trace of a scan from the spec timing; entries at or past lim are dropped.
   task automatic exp_scan(input int t0, input logic [15:0] m, input int d, input int nfr,
                           input int lim, output int tend);
      int  t;
      bit  pend;
      int  de;
      t    = t0;
      pend = 1'b0;
      de   = (d == 0) ? 1 : d;
      for (int f = 0; f < nfr; f++) begin
         for (int ch = 0; ch < 16; ch++) begin
            if (m[ch]) begin
               for (int k = 0; k < G; k++) begin
                  if (t < lim) expect_at(t, 4'(ch), 1'b0, 1'b1, pend);
                  pend = 1'b0;
                  t++;
               end
               for (int k = 0; k < de; k++) begin
                  if (t < lim) expect_at(t, 4'(ch), 1'b1, 1'b1, 1'b0);
                  t++;
               end
            end
         end
         pend = 1'b1;
      end
      tend = t;
   endtask

   task automatic launch(input logic [15:0] m, input int d, input logic c, input int nfr,
                         input int lim, output int t0, output int tend);
      t0      = cyc + 1;
      ch_mask = m;
      dwell   = 16'(d);
      cont    = c;
      start   = 1'b1;
      exp_scan(t0, m, d, nfr, lim, tend);
      wait_cyc(cyc + 1);
      start   = 1'b0;
   endtask

   initial begin
      int t0, tend, ta, c0;
      rst_n = 1'b0;
      start = 1'b0;
      stop = 1'b0;
      cont = 1'b0;
      dwell = 16'd0;
      ch_mask = 16'd0;
      for (int i = 2; i <= 5; i++) expect_at(i, 4'd0, 1'b0, 1'b0, 1'b0);
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(6);

      // Full frame, mask FFFF, dwell 3, single shot; a start while busy must be ignored.
      launch(16'hFFFF, 3, 1'b0, 1, BIG, t0, tend);
      expect_at(tend, 4'd15, 1'b0, 1'b0, 1'b1);
      expect_at(tend + 1, 4'd15, 1'b0, 1'b0, 1'b0);
      wait_cyc(t0 + 13);
      ch_mask = 16'h0001;
      dwell = 16'd9;
      cont = 1'b1;
      start = 1'b1;
      wait_cyc(t0 + 14);
      start = 1'b0;
      wait_cyc(tend + 2);

      // Sparse mask, continuous, two frames then stop.
      launch(16'h8421, 1, 1'b1, 2, BIG, t0, tend);
      expect_at(tend, 4'd0, 1'b0, 1'b1, 1'b1);
      wait_cyc(tend);
      stop = 1'b1;
      expect_at(tend + 1, 4'd0, 1'b0, 1'b0, 1'b0);
      wait_cyc(tend + 1);
      stop = 1'b0;
      expect_at(tend + 2, 4'd0, 1'b0, 1'b0, 1'b0);
      wait_cyc(tend + 3);

      // dwell 0 treated as 1 on channel 2.
      launch(16'h0004, 0, 1'b0, 1, BIG, t0, tend);
      expect_at(tend, 4'd2, 1'b0, 1'b0, 1'b1);
      expect_at(tend + 1, 4'd2, 1'b0, 1'b0, 1'b0);
      wait_cyc(tend + 2);

      // Empty mask: start ignored.
      c0 = cyc;
      ch_mask = 16'h0000;
      start = 1'b1;
      for (int i = 1; i <= 3; i++) expect_at(c0 + i, 4'd2, 1'b0, 1'b0, 1'b0);
      wait_cyc(c0 + 1);
      start = 1'b0;
      wait_cyc(c0 + 4);

      // Abort during channel 7 dwell, then restart from channel 0.
      ta = cyc + 1;
      launch(16'hFFFF, 3, 1'b0, 1, ta + 38, t0, tend);
      wait_cyc(ta + 37);
      stop = 1'b1;
      expect_at(ta + 38, 4'd7, 1'b0, 1'b0, 1'b0);
      expect_at(ta + 39, 4'd7, 1'b0, 1'b0, 1'b0);
      wait_cyc(ta + 38);
      stop = 1'b0;
      wait_cyc(ta + 40);
      ta = cyc + 1;
      launch(16'hFFFF, 1, 1'b0, 1, ta + 4, t0, tend);
      wait_cyc(ta + 3);
      stop = 1'b1;
      expect_at(ta + 4, 4'd1, 1'b0, 1'b0, 1'b0);
      wait_cyc(ta + 4);
      stop = 1'b0;

      // start and stop together in IDLE: stop wins.
      c0 = cyc;
      ch_mask = 16'hFFFF;
      start = 1'b1;
      stop = 1'b1;
      for (int i = 1; i <= 3; i++) expect_at(c0 + i, 4'd1, 1'b0, 1'b0, 1'b0);
      wait_cyc(c0 + 1);
      start = 1'b0;
      stop = 1'b0;
      wait_cyc(c0 + 4);

      // Reset during the guard of channel 9.
      ta = cyc + 1;
      launch(16'hFFFF, 2, 1'b0, 1, ta + 37, t0, tend);
      wait_cyc(ta + 36);
      rst_n = 1'b0;
      for (int i = 37; i <= 43; i++) expect_at(ta + i, 4'd0, 1'b0, 1'b0, 1'b0);
      wait_cyc(ta + 38);
      rst_n = 1'b1;
      wait_cyc(ta + 44);

      for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
